well_row_scanner: RTL

Reader-side companion to the well shifter. It walks the well's cell-status read port row by row, from bottom to top, and finds every completely filled row. Each full row index is handed to the line-clear / shift sequencer over a valid/ready handshake. The block sits between the well storage (status mux) and the game controller, and runs once per `start` pulse after a piece locks.

---
 rtl/well_row_scanner.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/well_row_scanner.sv
// well_row_scanner: walks the well status port bottom-to-top and offers each full row on a valid/ready port.
// Build option WELL_SCAN_EARLY_EXIT_EN: abandon a row on its first empty cell.
module well_row_scanner #(
  parameter int unsigned WELL_BLOCKS_ROW = 20,
  parameter int unsigned WELL_BLOCKS_COL = 10
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  output logic                                 busy,
  output logic [$clog2(WELL_BLOCKS_ROW)-1:0]   rd_row,
  output logic [$clog2(WELL_BLOCKS_COL)-1:0]   rd_col,
  input  logic                                 rd_status,
  output logic                                 full_valid,
  input  logic                                 full_ready,
  output logic [$clog2(WELL_BLOCKS_ROW)-1:0]   full_row,
  output logic [$clog2(WELL_BLOCKS_ROW+1)-1:0] full_count,
  output logic                                 done
);

  localparam int unsigned RW = $clog2(WELL_BLOCKS_ROW);
  localparam int unsigned CW = $clog2(WELL_BLOCKS_COL);
  localparam int unsigned NW = $clog2(WELL_BLOCKS_ROW + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_REPORT,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [RW-1:0] r_rd_row;
  logic [CW-1:0] r_rd_col;
  logic [RW-1:0] r_full_row;
  logic [NW-1:0] r_full_count;
  logic          r_acc;
  logic          r_busy;
  logic          r_full_valid;
  logic          r_done;

  logic w_last_col;
  logic w_last_row;
  logic w_row_full;
  logic w_row_dead;

  assign w_last_col = (r_rd_col == CW'(WELL_BLOCKS_COL - 1));
  assign w_last_row = (r_rd_row == '0);
  assign w_row_full = r_acc & rd_status;

  // An empty cell ends the row immediately only in the early-exit build.
`ifdef WELL_SCAN_EARLY_EXIT_EN
  assign w_row_dead = ~rd_status;
`else
  assign w_row_dead = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_rd_row     <= '0;
      r_rd_col     <= '0;
      r_full_row   <= '0;
      r_full_count <= '0;
      r_acc        <= 1'b0;
      r_busy       <= 1'b0;
      r_full_valid <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_SCAN;
            r_busy       <= 1'b1;
            r_rd_row     <= RW'(WELL_BLOCKS_ROW - 1);
            r_rd_col     <= '0;
            r_acc        <= 1'b1;
            r_full_count <= '0;
          end
        end

        S_SCAN: begin
          if (w_last_col || w_row_dead) begin
            if (w_row_full) begin
              r_state      <= S_REPORT;
              r_full_valid <= 1'b1;
              r_full_row   <= r_rd_row;
            end else if (w_last_row) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_rd_row <= r_rd_row - RW'(1);
              r_rd_col <= '0;
              r_acc    <= 1'b1;
            end
          end else begin
            r_rd_col <= r_rd_col + CW'(1);
            r_acc    <= w_row_full;
          end
        end

        // Hold the offer until the sequencer takes it, then resume with the row above.
        S_REPORT: begin
          if (full_ready) begin
            r_full_valid <= 1'b0;
            r_full_count <= r_full_count + NW'(1);
            if (w_last_row) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state  <= S_SCAN;
              r_rd_row <= r_rd_row - RW'(1);
              r_rd_col <= '0;
              r_acc    <= 1'b1;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign rd_row     = r_rd_row;
  assign rd_col     = r_rd_col;
  assign full_valid = r_full_valid;
  assign full_row   = r_full_row;
  assign full_count = r_full_count;
  assign done       = r_done;

endmodule
